// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO that drains at most one entry per cycle onto a single register-file write port.
// Build with WBQ_BYPASS_EN defined to forward pending data to the two read ports.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   wb_stall,
    output logic                   write_en,
    output logic [ADDR_W-1:0]      reg_addr_in,
    output logic [DATA_W-1:0]      data_in,
    input  logic [ADDR_W-1:0]      rd_addr_1,
    input  logic [ADDR_W-1:0]      rd_addr_2,
    output logic                   byp_hit_1,
    output logic [DATA_W-1:0]      byp_data_1,
    output logic                   byp_hit_2,
    output logic [DATA_W-1:0]      byp_data_2,
    output logic [$clog2(DEPTH):0] count,
    output logic                   idle
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    // Handshake: a request transfers on every posedge where in_valid && in_ready.
    // in_ready comes only from registered occupancy, so a same-cycle pop never raises it.
    assign in_ready    = (count_q != CNT_W'(DEPTH));
    assign push        = in_valid && in_ready;
    assign write_en    = (count_q != '0) && !wb_stall;
    assign pop         = write_en;
    assign reg_addr_in = addr_mem[rd_ptr];
    assign data_in     = data_mem[rd_ptr];
    assign count       = count_q;
    assign idle        = (count_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            data_mem[wr_ptr] <= in_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Walk from oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = rd_ptr;
        byp_hit_1  = 1'b0;
        byp_data_1 = '0;
        byp_hit_2  = 1'b0;
        byp_data_2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count_q) begin
                if (addr_mem[idx] == rd_addr_1) begin
                    byp_hit_1  = 1'b1;
                    byp_data_1 = data_mem[idx];
                end
                if (addr_mem[idx] == rd_addr_2) begin
                    byp_hit_2  = 1'b1;
                    byp_data_2 = data_mem[idx];
                end
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{rd_addr_1, rd_addr_2};
    assign byp_hit_1      = 1'b0;
    assign byp_data_1     = '0;
    assign byp_hit_2      = 1'b0;
    assign byp_data_2     = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue: directed table, corner sequences and
// randomized traffic against a queue-based reference model with its own register file image.
module tb_regfile_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;
    localparam int W      = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              wb_stall;
    logic              write_en;
    logic [ADDR_W-1:0] reg_addr_in;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic              byp_hit_1;
    logic [DATA_W-1:0] byp_data_1;
    logic              byp_hit_2;
    logic [DATA_W-1:0] byp_data_2;
    logic [CNT_W-1:0]  count;
    logic              idle;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] ref_mem [256];
    logic [DATA_W-1:0] rf_mem  [256];
    logic              rf_init;

    typedef struct packed {
        logic              v;
        logic              stall;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              exp_wen;
        logic              exp_ready;
        logic [CNT_W-1:0]  exp_count;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
    } vec_t;
    vec_t tv [14];

    regfile_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
        .write_en(write_en), .reg_addr_in(reg_addr_in), .data_in(data_in),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .byp_hit_1(byp_hit_1), .byp_data_1(byp_data_1),
        .byp_hit_2(byp_hit_2), .byp_data_2(byp_data_2),
        .count(count), .idle(idle)
    );

    always #5 clk = ~clk;

    // The register file the queue feeds, sampled from the DUT write port.
    always @(posedge clk) begin
        if (rf_init) begin
            for (int a = 0; a < 256; a++) rf_mem[a] <= '0;
        end else if (write_en) begin
            rf_mem[reg_addr_in] <= data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic s);
        @(negedge clk);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        wb_stall = s;
        #1;
    endtask

    // Compare outputs to the model, then advance model and DUT across one posedge.
    task automatic commit();
        logic              exp_ready;
        logic              exp_wen;
        logic              h1, h2;
        logic [DATA_W-1:0] d1, d2;
        logic [W-1:0]      head;
        exp_ready = (exp_q.size() != DEPTH);
        exp_wen   = (exp_q.size() != 0) && !wb_stall;
        check("in_ready", in_ready, exp_ready);
        check("write_en", write_en, exp_wen);
        check("count", count, 32'(exp_q.size()));
        check("idle", idle, exp_q.size() == 0);
        if (exp_wen) begin
            head = exp_q[0];
            check("head_addr", reg_addr_in, head[W-1:DATA_W]);
            check("head_data", data_in, head[DATA_W-1:0]);
        end
        h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
`ifdef WBQ_BYPASS_EN
        foreach (exp_q[i]) begin
            if (exp_q[i][W-1:DATA_W] == rd_addr_1) begin h1 = 1'b1; d1 = exp_q[i][DATA_W-1:0]; end
            if (exp_q[i][W-1:DATA_W] == rd_addr_2) begin h2 = 1'b1; d2 = exp_q[i][DATA_W-1:0]; end
        end
`endif
        check("byp_hit_1", byp_hit_1, h1);
        check("byp_data_1", byp_data_1, d1);
        check("byp_hit_2", byp_hit_2, h2);
        check("byp_data_2", byp_data_2, d2);
        if (exp_wen) begin
            head = exp_q.pop_front();
            ref_mem[head[W-1:DATA_W]] = head[DATA_W-1:0];
        end
        if (in_valid && exp_ready) exp_q.push_back({in_addr, in_data});
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic s);
        drive(v, a, d, s);
        commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        wb_stall = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * DEPTH && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b0);
        check("drain_idle", idle, 1'b1);
    endtask

    initial begin
        tv[0]  = '{1'b1, 1'b0, 8'h05, 16'h1234, 1'b0, 1'b1, 3'd0, 8'h00, 16'h0000};
        tv[1]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 3'd1, 8'h05, 16'h1234};
        tv[2]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 3'd0, 8'h00, 16'h0000};
        tv[3]  = '{1'b1, 1'b1, 8'h10, 16'hA000, 1'b0, 1'b1, 3'd0, 8'h00, 16'h0000};
        tv[4]  = '{1'b1, 1'b1, 8'h11, 16'hA001, 1'b0, 1'b1, 3'd1, 8'h00, 16'h0000};
        tv[5]  = '{1'b1, 1'b1, 8'h12, 16'hA002, 1'b0, 1'b1, 3'd2, 8'h00, 16'h0000};
        tv[6]  = '{1'b1, 1'b1, 8'h13, 16'hA003, 1'b0, 1'b1, 3'd3, 8'h00, 16'h0000};
        tv[7]  = '{1'b1, 1'b1, 8'h14, 16'hA004, 1'b0, 1'b0, 3'd4, 8'h00, 16'h0000};
        tv[8]  = '{1'b1, 1'b0, 8'h14, 16'hA004, 1'b1, 1'b0, 3'd4, 8'h10, 16'hA000};
        tv[9]  = '{1'b1, 1'b0, 8'h14, 16'hA004, 1'b1, 1'b1, 3'd3, 8'h11, 16'hA001};
        tv[10] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 3'd3, 8'h12, 16'hA002};
        tv[11] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 3'd2, 8'h13, 16'hA003};
        tv[12] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 3'd1, 8'h14, 16'hA004};
        tv[13] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 3'd0, 8'h00, 16'h0000};

        for (int a = 0; a < 256; a++) ref_mem[a] = '0;
        rst = 1'b1; rf_init = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wb_stall = 1'b1; rd_addr_1 = 8'hFF; rd_addr_2 = 8'hFE;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rf_init = 1'b0;

        // Reset state
        drive(1'b0, '0, '0, 1'b0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_wen", write_en, 1'b0);
        check("rst_idle", idle, 1'b1);
        commit();

        // Single write latency, then fill-while-stalled and gapless drain
        for (int i = 0; i < 14; i++) begin
            drive(tv[i].v, tv[i].addr, tv[i].data, tv[i].stall);
            check($sformatf("tv%0d_wen", i), write_en, tv[i].exp_wen);
            check($sformatf("tv%0d_ready", i), in_ready, tv[i].exp_ready);
            check($sformatf("tv%0d_count", i), count, tv[i].exp_count);
            if (tv[i].exp_wen) begin
                check($sformatf("tv%0d_addr", i), reg_addr_in, tv[i].exp_addr);
                check($sformatf("tv%0d_data", i), data_in, tv[i].exp_data);
            end
            commit();
        end
        check("mem5", rf_mem[8'h05], 16'h1234);
        for (int a = 8'h10; a <= 8'h14; a++)
            check($sformatf("mem%0h", a), rf_mem[a], 16'hA000 + 16'(a - 8'h10));

        // Continuous streaming with pointer wrap
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 8'h40 + 8'(i), 16'hC000 + 16'(i), 1'b0);
            if (i > 0) check("stream_count", count, 1);
            commit();
        end
        drain();
        for (int i = 0; i < 12; i++)
            check("stream_mem", rf_mem[8'h40 + i], 16'hC000 + 16'(i));

        // Two pending writes to one register, youngest forwarded
        rd_addr_1 = 8'h03; rd_addr_2 = 8'h04;
        step(1'b1, 8'h03, 16'hAAAA, 1'b1);
        step(1'b1, 8'h03, 16'hBBBB, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
`ifdef WBQ_BYPASS_EN
        check("s4_hit1", byp_hit_1, 1'b1);
        check("s4_data1", byp_data_1, 16'hBBBB);
`else
        check("s4_hit1", byp_hit_1, 1'b0);
        check("s4_data1", byp_data_1, 16'h0000);
`endif
        check("s4_hit2", byp_hit_2, 1'b0);
        check("s4_data2", byp_data_2, 16'h0000);
        commit();
        drain();
        check("s4_mem3", rf_mem[8'h03], 16'hBBBB);

        // Reset with pending entries discards them unwritten
        rd_addr_1 = 8'h20; rd_addr_2 = 8'h22;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 16'hDEAD, 1'b1);
        do_reset();
        drive(1'b0, '0, '0, 1'b0);
        check("s5_count", count, 0);
        check("s5_wen", write_en, 1'b0);
        check("s5_ready", in_ready, 1'b1);
        check("s5_hit1", byp_hit_1, 1'b0);
        commit();
        for (int i = 0; i < 3; i++)
            check("s5_mem", rf_mem[8'h20 + i], ref_mem[8'h20 + i]);

        // Randomized traffic with frequent address collisions
        for (int i = 0; i < 400; i++) begin
            rd_addr_1 = 8'($urandom_range(7, 0));
            rd_addr_2 = 8'($urandom_range(7, 0));
            step($urandom_range(9, 0) < 7, 8'($urandom_range(7, 0)), 16'($urandom),
                 $urandom_range(3, 0) == 0);
        end
        drain();
        for (int a = 0; a < 64; a++) check("final_mem", rf_mem[a], ref_mem[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
